// File: rtl/cmp_pkg.sv
// Shared definitions for the arbitrated equality-comparator sequencer:
// FSM state encoding, op and port-ID constants, and the round-robin pick.
package cmp_pkg;

    // Sequencer states: idle/arbitrate, compare, hold response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Operation select carried with each request
    localparam logic OP_EQ = 1'b0;
    localparam logic OP_NE = 1'b1;

    // Requester identities, also used as the response tag
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Width of the per-port grant counters
    localparam int CNT_W = 8;

    // Round-robin pick between the two requesters. A lone requester wins
    // regardless of the pointer; the pointer only breaks ties.
    // Returns a one-hot (or zero) grant vector, bit N for port N.
    function automatic logic [1:0] rr_grant(input logic v0,
                                            input logic v1,
                                            input logic ptr);
        logic [1:0] g;
        g[0] = v0 && (!v1 || (ptr == PORT0));
        g[1] = v1 && (!v0 || (ptr == PORT1));
        return g;
    endfunction

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the two requesters, the response
// consumer and the comparator sequencer. The master side is the
// requester/consumer environment; the slave side is the sequencer.
interface cmp_arbiter_if #(
    parameter int WIDTH = 8
);
    import cmp_pkg::*;

    // Port 0: branch-resolve logic
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ne;

    // Port 1: loop/compare-instruction logic
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ne;

    // Shared response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_flag;

    // Status
    logic             busy;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    modport master (
        output req0_valid, req0_a, req0_b, req0_ne,
        output req1_valid, req1_a, req1_b, req1_ne,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_flag,
        input  busy, gnt_cnt0, gnt_cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ne,
        input  req1_valid, req1_a, req1_b, req1_ne,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_flag,
        output busy, gnt_cnt0, gnt_cnt1
    );

endinterface

// File: rtl/cmp_arbiter_eq_cmp.sv
// Purely combinational WIDTH-bit unsigned equality compare.
module eq_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_o
);

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/cmp_arbiter.sv
// Two-port round-robin sequencer in front of a single equality comparator.
// A granted request is latched, compared in the following cycle and held
// as a tagged response until the consumer accepts it. WIDTH must match
// the WIDTH of the connected cmp_arbiter_if.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    cmp_arbiter_if.slave  bus
);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             ne_q, ne_d;
    logic             id_q, id_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic [1:0]       gnt;
    logic             eq;

    // Single shared comparator, always fed from the latched operands so
    // requester activity after the grant cannot disturb the result.
    eq_cmp #(
        .WIDTH (WIDTH)
    ) u_eq_cmp (
        .a_i  (a_q),
        .b_i  (b_q),
        .eq_o (eq)
    );

    // Next-state, arbitration and operand-capture logic
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned; a missing default infers a latch.
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        ne_d     = ne_q;
        id_d     = id_q;
        flag_d   = flag_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        gnt      = 2'b00;

        case (state_q)
            IDLE: begin
                gnt = rr_grant(bus.req0_valid, bus.req1_valid, rr_ptr_q);
                if (gnt[0]) begin
                    a_d     = bus.req0_a;
                    b_d     = bus.req0_b;
                    ne_d    = bus.req0_ne;
                    id_d    = PORT0;
                    cnt0_d  = cnt0_q + CNT_W'(1);
                    state_d = CMP;
                end else if (gnt[1]) begin
                    a_d     = bus.req1_a;
                    b_d     = bus.req1_b;
                    ne_d    = bus.req1_ne;
                    id_d    = PORT1;
                    cnt1_d  = cnt1_q + CNT_W'(1);
                    state_d = CMP;
                end
            end

            CMP: begin
                // NE op inverts the equality result
                flag_d  = eq ^ (ne_q == OP_NE);
                state_d = RESP;
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    // The port just served loses the next tie
                    rr_ptr_d = ~id_q;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, latched request, result and grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched operands are plain registers, not a memory
            // array, so they are cleared with the rest of the state and
            // never expose stale data after reset.
            state_q  <= IDLE;
            rr_ptr_q <= PORT0;
            a_q      <= '0;
            b_q      <= '0;
            ne_q     <= OP_EQ;
            id_q     <= PORT0;
            flag_q   <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ne_q     <= ne_d;
            id_q     <= id_d;
            flag_q   <= flag_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    // Ready is suppressed while reset is held: the FSM cannot take a
    // grant then, so no handshake may be reported to a requester.
    assign bus.req0_ready = gnt[0] && rst_n;
    assign bus.req1_ready = gnt[1] && rst_n;

    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_flag   = flag_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.gnt_cnt0   = cnt0_q;
    assign bus.gnt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed, table-driven bench for cmp_arbiter: single-port vectors from a
// table, then hand-written contention, backpressure, mid-op reset and
// counter-wrap sequences. Inputs change on the falling edge and outputs
// are sampled 1 time unit later.
module tb_cmp_arbiter;
    import cmp_pkg::*;

    localparam int WIDTH = 8;

    typedef struct {
        logic       port;
        logic [7:0] a;
        logic [7:0] b;
        logic       ne;
        logic       flag;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cmp_arbiter_if #(.WIDTH(WIDTH)) bus ();

    cmp_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_cnt0 = 8'd0;
    logic [7:0] m_cnt1 = 8'd0;
    vec_t       vecs [8];

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive_port(input logic port, input logic v,
                              input logic [7:0] a, input logic [7:0] b, input logic ne);
        if (port == PORT0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ne = ne;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ne = ne;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, " busy"}, bus.busy, 1'b0);
        check1({tag, " rsp_valid"}, bus.rsp_valid, 1'b0);
        check1({tag, " rsp_id"}, bus.rsp_id, 1'b0);
        check1({tag, " rsp_flag"}, bus.rsp_flag, 1'b0);
        check1({tag, " req0_ready"}, bus.req0_ready, 1'b0);
        check1({tag, " req1_ready"}, bus.req1_ready, 1'b0);
        check8({tag, " gnt_cnt0"}, bus.gnt_cnt0, 8'h00);
        check8({tag, " gnt_cnt1"}, bus.gnt_cnt1, 8'h00);
    endtask

    // One uncontended transaction: grant at T, compare at T+1, response at
    // T+2 accepted immediately. Operands are scrambled after the grant.
    task automatic do_txn(input string tag, input logic port, input logic [7:0] a,
                          input logic [7:0] b, input logic ne, input logic flag);
        @(negedge clk);
        drive_port(port, 1'b1, a, b, ne);
        bus.rsp_ready = 1'b1;
        #1;
        check1({tag, " ready granted"}, port ? bus.req1_ready : bus.req0_ready, 1'b1);
        check1({tag, " ready other"}, port ? bus.req0_ready : bus.req1_ready, 1'b0);
        if (port == PORT0) m_cnt0++; else m_cnt1++;
        @(negedge clk);
        drive_port(port, 1'b0, ~a, ~b, ~ne);
        #1;
        check1({tag, " T+1 busy"}, bus.busy, 1'b1);
        check1({tag, " T+1 rsp_valid"}, bus.rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        check1({tag, " T+2 rsp_valid"}, bus.rsp_valid, 1'b1);
        check1({tag, " rsp_id"}, bus.rsp_id, port);
        check1({tag, " rsp_flag"}, bus.rsp_flag, flag);
        check8({tag, " gnt_cnt0"}, bus.gnt_cnt0, m_cnt0);
        check8({tag, " gnt_cnt1"}, bus.gnt_cnt1, m_cnt1);
    endtask

    initial begin
        logic exp_port;
        int   k;

        vecs[0] = '{port: PORT0, a: 8'h5A, b: 8'h5A, ne: OP_EQ, flag: 1'b1};
        vecs[1] = '{port: PORT1, a: 8'h00, b: 8'hFF, ne: OP_NE, flag: 1'b1};
        vecs[2] = '{port: PORT1, a: 8'h00, b: 8'hFF, ne: OP_EQ, flag: 1'b0};
        vecs[3] = '{port: PORT0, a: 8'h33, b: 8'h33, ne: OP_NE, flag: 1'b0};
        vecs[4] = '{port: PORT0, a: 8'h00, b: 8'h00, ne: OP_EQ, flag: 1'b1};
        vecs[5] = '{port: PORT1, a: 8'hFF, b: 8'hFF, ne: OP_EQ, flag: 1'b1};
        vecs[6] = '{port: PORT0, a: 8'h80, b: 8'h01, ne: OP_NE, flag: 1'b1};
        vecs[7] = '{port: PORT1, a: 8'hA5, b: 8'hA5, ne: OP_NE, flag: 1'b0};

        drive_port(PORT0, 1'b0, 8'h00, 8'h00, OP_EQ);
        drive_port(PORT1, 1'b0, 8'h00, 8'h00, OP_EQ);
        bus.rsp_ready = 1'b0;

        // Reset state, with a valid asserted to confirm ready stays low
        repeat (2) @(negedge clk);
        bus.req0_valid = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;

        // Table-driven single-requester vectors; last entry is port 1,
        // leaving the pointer at port 0 for the contention sequence.
        for (int i = 0; i < 8; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b,
                   vecs[i].ne, vecs[i].flag);
        end

        // Sustained contention: grants every third cycle, order 0,1,0,1
        @(negedge clk);
        drive_port(PORT0, 1'b1, 8'h11, 8'h11, OP_EQ);
        drive_port(PORT1, 1'b1, 8'h22, 8'h23, OP_EQ);
        bus.rsp_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_port = k[0];
            if (c % 3 == 0) begin
                check1($sformatf("cont%0d ready0", k), bus.req0_ready, exp_port == PORT0);
                check1($sformatf("cont%0d ready1", k), bus.req1_ready, exp_port == PORT1);
                if (exp_port == PORT0) m_cnt0++; else m_cnt1++;
            end else if (c % 3 == 1) begin
                check1($sformatf("cont%0d rsp_valid early", k), bus.rsp_valid, 1'b0);
                check1($sformatf("cont%0d ready0 busy", k), bus.req0_ready, 1'b0);
            end else begin
                check1($sformatf("cont%0d rsp_valid", k), bus.rsp_valid, 1'b1);
                check1($sformatf("cont%0d rsp_id", k), bus.rsp_id, exp_port);
                check1($sformatf("cont%0d rsp_flag", k), bus.rsp_flag, exp_port == PORT0);
                k++;
            end
            @(negedge clk);
        end
        drive_port(PORT0, 1'b0, 8'h00, 8'h00, OP_EQ);
        drive_port(PORT1, 1'b0, 8'h00, 8'h00, OP_EQ);
        #1;
        check8("cont gnt_cnt0", bus.gnt_cnt0, m_cnt0);
        check8("cont gnt_cnt1", bus.gnt_cnt1, m_cnt1);

        // Backpressure: response held 5 cycles while req0 stays valid
        @(negedge clk);
        drive_port(PORT0, 1'b1, 8'h3C, 8'h3C, OP_EQ);
        bus.rsp_ready = 1'b0;
        #1;
        check1("bp grant", bus.req0_ready, 1'b1);
        m_cnt0++;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check1($sformatf("bp%0d rsp_valid", c), bus.rsp_valid, 1'b1);
            check1($sformatf("bp%0d rsp_id", c), bus.rsp_id, PORT0);
            check1($sformatf("bp%0d rsp_flag", c), bus.rsp_flag, 1'b1);
            check1($sformatf("bp%0d req0_ready", c), bus.req0_ready, 1'b0);
            check1($sformatf("bp%0d busy", c), bus.busy, 1'b1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check1("bp regrant", bus.req0_ready, 1'b1);
        check8("bp gnt_cnt0", bus.gnt_cnt0, m_cnt0);
        // Valid withdrawn before the edge: never granted
        bus.req0_valid = 1'b0;
        #1;
        check1("bp withdraw", bus.req0_ready, 1'b0);

        // Reset during CMP: response discarded, held req0 re-granted
        @(negedge clk);
        drive_port(PORT0, 1'b1, 8'h07, 8'h07, OP_EQ);
        #1;
        check1("rst grant", bus.req0_ready, 1'b1);
        @(negedge clk);
        #1;
        check1("rst in CMP busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check1("midrst hold rsp_valid", bus.rsp_valid, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("post-rst grant", bus.req0_ready, 1'b1);
        m_cnt0++;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        check1("post-rst T+1 rsp_valid", bus.rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        check1("post-rst rsp_valid", bus.rsp_valid, 1'b1);
        check1("post-rst rsp_id", bus.rsp_id, PORT0);
        check1("post-rst rsp_flag", bus.rsp_flag, 1'b1);
        check8("post-rst gnt_cnt0", bus.gnt_cnt0, 8'h01);

        // Counter wrap: fresh reset, then 256 grants to port 0
        @(negedge clk);
        rst_n = 1'b0;
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            do_txn($sformatf("wrap%0d", i), PORT0, 8'(i), 8'(i), i[0], ~i[0]);
        end
        @(negedge clk);
        #1;
        check8("wrap gnt_cnt0", bus.gnt_cnt0, 8'h00);
        check8("wrap gnt_cnt1", bus.gnt_cnt1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
